// File: rtl/axi_read_slave_pkg.sv
// Shared protocol types for the AXI3-style read responder.
package axiprotocol;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Wrap bursts must span a power-of-two number of beats (2, 4, 8 or 16).
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_read_slave_addr_gen.sv
// Next-beat address for FIXED/INCR bursts, plus WRAP when AXI_RD_WRAP_BURST_EN is defined.
module axi_rd_addr_gen
  import axiprotocol::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3
) (
  input  logic [WIDTH-1:0]   addr_i,
  input  logic [SIZE-1:0]    size_i,
  input  logic [WIDTH/8-1:0] len_i,
  input  logic [SIZE-2:0]    burst_i,
  output logic [WIDTH-1:0]   next_addr_o
);

  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] incr_addr;

  assign step      = WIDTH'(1) << size_i;
  assign incr_addr = addr_i + step;

`ifdef AXI_RD_WRAP_BURST_EN
  logic [WIDTH-1:0] total;
  logic [WIDTH-1:0] boundary;

  // The window is aligned to its own size, so the current beat address
  // yields the same boundary as the original ARADDR.
  assign total    = (WIDTH'(len_i) + WIDTH'(1)) << size_i;
  assign boundary = addr_i & ~(total - WIDTH'(1));
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      INCR:    next_addr_o = incr_addr;
`ifdef AXI_RD_WRAP_BURST_EN
      WRAP:    next_addr_o = (incr_addr == boundary + total) ? boundary : incr_addr;
`endif
      default: next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI3-style single-outstanding read slave backed by a side-port-loaded word memory.
// Optional WRAP burst support is enabled by defining AXI_RD_WRAP_BURST_EN.
module axi_read_slave
  import axiprotocol::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 3,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  input  logic [WIDTH/8-1:0]           ARID,
  input  logic [WIDTH-1:0]             ARADDR,
  input  logic [WIDTH/8-1:0]           ARLEN,
  input  logic [SIZE-1:0]              ARSIZE,
  input  logic [SIZE-2:0]              ARBURST,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [WIDTH/8-1:0]           RID,
  output logic [WIDTH-1:0]             RDATA,
  output logic [SIZE-2:0]              RRESP,
  output logic                         RLAST,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [WIDTH-1:0]             mem_wdata
);

  localparam int LW        = WIDTH / 8;
  localparam int LANE_BITS = $clog2(LW);
  localparam int AW        = $clog2(MEM_DEPTH);

  state_t           state_q;
  logic             arready_q;
  logic             rvalid_q;
  logic             rlast_q;
  logic             slverr_q;
  logic [LW-1:0]    id_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    beat_q;
  logic [LW-1:0]    beat_d;
  logic [SIZE-1:0]  size_q;
  logic [SIZE-2:0]  burst_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] rdata_q;
  resp_t            rresp_q;

  logic [WIDTH-1:0] mem [MEM_DEPTH];

  logic [WIDTH-1:0] next_addr;
  logic [WIDTH-1:0] load_addr;
  logic [WIDTH-1:0] load_data;
  resp_t            load_resp;
  logic             ar_slverr;
  logic             load_slverr;

  axi_rd_addr_gen #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Whole-burst SLVERR decision, evaluated on the incoming AR request.
  always_comb begin
    ar_slverr = (ARSIZE > SIZE'(LANE_BITS));
`ifdef AXI_RD_WRAP_BURST_EN
    if (&ARBURST) ar_slverr = 1'b1;
    if (ARBURST == WRAP) begin
      if (!wrap_len_ok(8'(ARLEN)) ||
          ((ARADDR & ((WIDTH'(1) << ARSIZE) - WIDTH'(1))) != '0))
        ar_slverr = 1'b1;
    end
`else
    if (ARBURST[SIZE-2]) ar_slverr = 1'b1;
`endif
  end

  // Beat 0 comes from the AR inputs; later beats from the address generator.
  assign load_addr   = (state_q == IDLE) ? ARADDR : next_addr;
  assign load_slverr = (state_q == IDLE) ? ar_slverr : slverr_q;
  assign beat_d      = beat_q + LW'(1);

  always_comb begin
    load_data = '0;
    load_resp = OKAY;
    if (load_slverr)
      load_resp = SLVERR;
    else if ((load_addr >> LANE_BITS) >= WIDTH'(MEM_DEPTH))
      load_resp = DECERR;
    else
      load_data = mem[load_addr[AW+LANE_BITS-1:LANE_BITS]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      slverr_q  <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (ARVALID) begin
            id_q      <= ARID;
            addr_q    <= ARADDR;
            len_q     <= ARLEN;
            size_q    <= ARSIZE;
            burst_q   <= ARBURST;
            slverr_q  <= ar_slverr;
            beat_q    <= '0;
            rdata_q   <= load_data;
            rresp_q   <= load_resp;
            rlast_q   <= (ARLEN == '0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              beat_q  <= beat_d;
              addr_q  <= next_addr;
              rdata_q <= load_data;
              rresp_q <= load_resp;
              rlast_q <= (beat_d == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = id_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Scoreboard bench for axi_read_slave; WRAP expectations follow AXI_RD_WRAP_BURST_EN.
module tb_axi_read_slave;
  import axiprotocol::*;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        mem_we = 1'b0;
  logic [7:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;

  axi_read_slave #(
    .WIDTH     (32),
    .SIZE      (3),
    .MEM_DEPTH (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic [3:0] id,
                      input logic last);
    beat_t b;
    b.data = d;
    b.resp = r;
    b.id   = id;
    b.last = last;
    q.push_back(b);
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_waddr = a;
    mem_wdata = d;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
  endtask

  // Returns one time unit after the AR handshake edge.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = len;
    ARSIZE  = size;
    ARBURST = burst;
    ARVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ARREADY && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ar_accept", {31'b0, ARREADY}, 32'd1);
    check("rvalid_before_ar", {31'b0, RVALID}, 32'd0);
    @(posedge clk);
    #1;
    ARVALID = 1'b0;
    check("first_beat_latency", {31'b0, RVALID}, 32'd1);
    check("arready_busy", {31'b0, ARREADY}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || RVALID) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending_beats", q.size(), 32'd0);
  endtask

  // Monitor: peeks at every presented beat, pops only on the handshake.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset && RVALID) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL r_beat: unexpected beat data=%h resp=%b id=%h last=%b",
                   RDATA, RRESP, RID, RLAST);
        end else begin
          e = q[0];
          if (RDATA !== e.data || RRESP !== e.resp || RID !== e.id || RLAST !== e.last) begin
            errors++;
            $display("FAIL r_beat: got data=%h resp=%b id=%h last=%b expected data=%h resp=%b id=%h last=%b",
                     RDATA, RRESP, RID, RLAST, e.data, e.resp, e.id, e.last);
          end
          if (RREADY) q.delete(0);
        end
      end
    end
  end

  initial begin
    logic [11:0] pat;
    pat = 12'b1111_0110_1001;

    #1 reset = 1'b1;
    #2;
    check("reset_arready", {31'b0, ARREADY}, 32'd1);
    check("reset_rvalid", {31'b0, RVALID}, 32'd0);
    check("reset_rlast", {31'b0, RLAST}, 32'd0);
    check("reset_rid", {28'b0, RID}, 32'd0);
    check("reset_rdata", RDATA, 32'd0);
    check("reset_rresp", {30'b0, RRESP}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    mem_write(8'd4, 32'h11);
    mem_write(8'd5, 32'h22);
    mem_write(8'd6, 32'h33);
    mem_write(8'd7, 32'h44);
    mem_write(8'd255, 32'hDEAD_BEEF);
    RREADY = 1'b1;

    // INCR, four beats
    push(32'h11, OKAY, 4'd5, 1'b0);
    push(32'h22, OKAY, 4'd5, 1'b0);
    push(32'h33, OKAY, 4'd5, 1'b0);
    push(32'h44, OKAY, 4'd5, 1'b1);
    send_ar(4'd5, 32'h10, 4'd3, 3'd2, 2'b01);
    drain();

    // WRAP from mid-window, then a FIXED request left pending during the burst
`ifdef AXI_RD_WRAP_BURST_EN
    push(32'h33, OKAY, 4'd6, 1'b0);
    push(32'h44, OKAY, 4'd6, 1'b0);
    push(32'h11, OKAY, 4'd6, 1'b0);
    push(32'h22, OKAY, 4'd6, 1'b1);
`else
    push(32'h0, SLVERR, 4'd6, 1'b0);
    push(32'h0, SLVERR, 4'd6, 1'b0);
    push(32'h0, SLVERR, 4'd6, 1'b0);
    push(32'h0, SLVERR, 4'd6, 1'b1);
`endif
    send_ar(4'd6, 32'h18, 4'd3, 3'd2, 2'b10);
    push(32'h22, OKAY, 4'd7, 1'b0);
    push(32'h22, OKAY, 4'd7, 1'b0);
    push(32'h22, OKAY, 4'd7, 1'b1);
    send_ar(4'd7, 32'h14, 4'd2, 3'd2, 2'b00);
    drain();

    // Back-pressure pattern on an INCR burst
    push(32'h11, OKAY, 4'd9, 1'b0);
    push(32'h22, OKAY, 4'd9, 1'b0);
    push(32'h33, OKAY, 4'd9, 1'b0);
    push(32'h44, OKAY, 4'd9, 1'b1);
    send_ar(4'd9, 32'h10, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 12; i++) begin
      RREADY = pat[i];
      @(posedge clk);
      #1;
    end
    RREADY = 1'b1;
    drain();

    // Last word then out of range
    push(32'hDEAD_BEEF, OKAY, 4'd10, 1'b0);
    push(32'h0, DECERR, 4'd10, 1'b1);
    send_ar(4'd10, 32'h3FC, 4'd1, 3'd2, 2'b01);
    drain();

    // Oversized beat, reserved burst type, illegal wrap length
    push(32'h0, SLVERR, 4'd11, 1'b0);
    push(32'h0, SLVERR, 4'd11, 1'b1);
    send_ar(4'd11, 32'h10, 4'd1, 3'd3, 2'b01);
    drain();
    push(32'h0, SLVERR, 4'd12, 1'b1);
    send_ar(4'd12, 32'h10, 4'd0, 3'd2, 2'b11);
    drain();
    push(32'h0, SLVERR, 4'd3, 1'b0);
    push(32'h0, SLVERR, 4'd3, 1'b0);
    push(32'h0, SLVERR, 4'd3, 1'b1);
    send_ar(4'd3, 32'h10, 4'd2, 3'd2, 2'b10);
    drain();

    // Reset after beat 1 of a four-beat burst
    push(32'h11, OKAY, 4'd13, 1'b0);
    push(32'h22, OKAY, 4'd13, 1'b0);
    push(32'h33, OKAY, 4'd13, 1'b0);
    push(32'h44, OKAY, 4'd13, 1'b1);
    send_ar(4'd13, 32'h10, 4'd3, 3'd2, 2'b01);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rvalid_async_drop", {31'b0, RVALID}, 32'd0);
    check("beats_before_reset", q.size(), 32'd2);
    q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arready_after_reset", {31'b0, ARREADY}, 32'd1);
    check("rvalid_after_reset", {31'b0, RVALID}, 32'd0);
    @(posedge clk);
    #1;
    push(32'h44, OKAY, 4'd14, 1'b1);
    send_ar(4'd14, 32'h1C, 4'd0, 3'd2, 2'b01);
    drain();

    // Side-port write while a beat is stalled affects only later beats
    RREADY = 1'b0;
    push(32'h22, OKAY, 4'd15, 1'b0);
    push(32'h99, OKAY, 4'd15, 1'b0);
    push(32'h99, OKAY, 4'd15, 1'b1);
    send_ar(4'd15, 32'h14, 4'd2, 3'd2, 2'b00);
    mem_write(8'd5, 32'h99);
    @(posedge clk);
    #1;
    RREADY = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
# axi_read_slave

AXI3-style read responder: accepts one read-address transaction at a time on the AR channel and returns the burst on the R channel from an internal word memory. It is the slave-side counterpart to the bus master driven from the verification BFM. It sits inside the DUV next to the write-channel logic. A simple side port preloads and updates the memory.

## Interface
- WIDTH, 32, data and address width; byte lanes = WIDTH/8
- SIZE, 3, AxSIZE width; AxBURST and xRESP are SIZE-1 bits wide
- MEM_DEPTH, 256, memory depth in WIDTH-bit words

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ARVALID  in  1  address valid
- ARREADY  out  1  address ready
- ARID  in  WIDTH/8  transaction ID
- ARADDR  in  WIDTH  byte address
- ARLEN  in  WIDTH/8  beats minus one
- ARSIZE  in  SIZE  bytes per beat = 2**ARSIZE
- ARBURST  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP
- RVALID  out  1  read data valid
- RREADY  in  1  master ready
- RID  out  WIDTH/8  echoes the latched ARID
- RDATA  out  WIDTH  read word
- RRESP  out  SIZE-1  00 OKAY, 10 SLVERR, 11 DECERR
- RLAST  out  1  final beat
- mem_we  in  1  side-port word write
- mem_waddr  in  $clog2(MEM_DEPTH)  word index
- mem_wdata  in  WIDTH  write data

## Operation
- FSM states:
  - IDLE: ARREADY=1. On ARVALID, latch ID, ADDR, LEN, SIZE and BURST, reset the beat counter, load beat 0, and go to BURST.
  - BURST: ARREADY=0, RVALID=1. On RVALID&&RREADY, advance the beat. On the handshake with RLAST=1, go to IDLE.
- Word index = addr[...:2]. An index >= MEM_DEPTH gives DECERR and RDATA=0 for that beat only.
- ARSIZE > log2(WIDTH/8) gives SLVERR and RDATA=0 for every beat of the burst.
- Next-address rules:
  - FIXED: address unchanged.
  - INCR: addr + 2**ARSIZE.
  - WRAP: boundary = ARADDR aligned down to (ARLEN+1)*2**ARSIZE. When the next address reaches boundary + total, it returns to the boundary.
- WRAP bursts with ARLEN not in {1,3,7,15}, or an unaligned ARADDR, get SLVERR on all beats.
- RLAST=1 exactly when beat count == latched ARLEN.
- Side port: mem_we writes mem[mem_waddr] on the clock edge. An update takes effect on the next beat loaded, never on the beat being presented.

## Timing
- Reset values: ARREADY=1 (the FSM is in IDLE); RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=00. Memory contents are not reset.
- AR handshake on edge N: first beat valid after edge N, so RVALID is high in cycle N+1.
- Throughput: with RREADY held high, one beat per cycle.
- Total occupancy: ARLEN+1 cycles plus one IDLE cycle before the next AR accept, i.e. no AR/R overlap.
- While RVALID=1 and RREADY=0, RDATA, RRESP, RID and RLAST are held stable.
- reset asserted mid-burst: RVALID drops immediately (asynchronously), the FSM returns to IDLE and the burst is discarded.
- ARVALID asserted during BURST is ignored and stays pending until ARREADY rises.

## Configuration
- AXI_RD_WRAP_BURST_EN defined: WRAP bursts are supported as described above.
- AXI_RD_WRAP_BURST_EN undefined: ARBURST=10, and the reserved value 11, return SLVERR with RDATA=0 for ARLEN+1 beats. The wrap logic is not synthesized.
- With or without the macro, ARBURST=11 always returns SLVERR.

## Structure
- Package axiprotocol holds:
  - enum burst_t {FIXED, INCR, WRAP}
  - enum resp_t {OKAY, EXOKAY, SLVERR, DECERR}
  - the FSM state enum {IDLE, BURST}
- One sub-module, axi_rd_addr_gen: combinational next-address calculation from addr, size, len and burst, including the wrap boundary.

## Test plan
- Preload mem[4..7] = 32'h11,22,33,44. Send ARADDR=0x10, ARLEN=3, SIZE=2, INCR, ARID=5 -> four beats 0x11,0x22,0x33,0x44, RID=5, OKAY, RLAST on the fourth beat, first RVALID one cycle after the AR handshake.
- Same preload, ARADDR=0x18, ARLEN=3, WRAP -> beats 0x33,0x44,0x11,0x22.
- FIXED, ARADDR=0x14, ARLEN=2 -> 0x22 three times.
- RREADY toggled 1,0,0,1,... during an INCR burst -> outputs held while RREADY=0, with no beat lost or duplicated.
- ARADDR=(MEM_DEPTH-1)*4, ARLEN=1, INCR -> beat 0 OKAY, beat 1 DECERR with RDATA=0.
- reset pulsed after beat 1 of a 4-beat burst -> RVALID=0 immediately and ARREADY=1 after reset releases. A new AR is then served correctly.
